// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam int INST_BYTES = 4;

  typedef logic [XLEN-1:0] inst_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef struct packed {
    addr_t pc;
    inst_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Synchronous FIFO with flush; holds fetched {pc,instr} pairs or, with a narrower
// entry type, the PCs of requests still in flight at the Icache.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-2 depths work for the in-flight FIFO.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

  // The caller's credit scheme must never push into a full queue without a pop.
  assert property (@(posedge clk) disable iff (rst)
    (push && !flush) |-> (!full || pop));

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: sequential PC generation, credit-limited Icache requests, in-order
// responses into a fetch queue, and redirect handling by dropping stale responses.
module if_fetch_unit #(
  parameter int              XLEN      = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = if_pkg::RESET_PC_DEFAULT,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            icache_req_o,
  output logic [XLEN-1:0] icache_req_pc_o,
  input  logic            icache_req_rdy_i,
  input  logic            icache_rsp_vld_i,
  input  logic [XLEN-1:0] icache_rsp_ins_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o,
  input  logic            id_ready_i
);

  import if_pkg::*;

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [OW-1:0]   outst_q;
  logic [OW-1:0]   outst_next;
  logic [OW-1:0]   drop_q;
  logic [QW-1:0]   fq_count;
  logic [OW-1:0]   pc_cnt;
  logic [XLEN-1:0] inflight_pc;
  logic            credit_ok;
  logic            fire;
  logic            rsp_drop;
  logic            rsp_accept;
  logic            fq_pop;
  entry_t          fq_push_data;
  entry_t          fq_head;

  // Every request must already own a queue slot, so responses never need back-pressure.
  assign credit_ok = (32'(outst_q) < 32'(MAX_OUTST)) &&
                     ((32'(outst_q) + 32'(fq_count)) < 32'(FQ_DEPTH));

  assign icache_req_o    = ~rst & ~redirect_valid_i & credit_ok;
  assign icache_req_pc_o = pc_q;

  assign fire       = icache_req_o & icache_req_rdy_i;
  assign rsp_drop   = icache_rsp_vld_i & (redirect_valid_i | (drop_q != '0));
  assign rsp_accept = icache_rsp_vld_i & ~rsp_drop;
  assign fq_pop     = id_valid_o & id_ready_i;

  always_comb begin
    outst_next = outst_q;
    case ({fire, icache_rsp_vld_i})
      2'b10:   outst_next = outst_q + 1'b1;
      2'b01:   outst_next = outst_q - 1'b1;
      default: outst_next = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      outst_q <= outst_next;
      if (redirect_valid_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc_q   <= redirect_pc_i;
        drop_q <= outst_q + OW'(fire) - OW'(icache_rsp_vld_i);
      end else begin
        if (fire) pc_q <= pc_q + XLEN'(INST_BYTES);
        if (icache_rsp_vld_i && (drop_q != '0)) drop_q <= drop_q - 1'b1;
      end
    end
  end

  // PCs of live requests, so each accepted response can be tagged with its address.
  if_fetch_queue #(
    .DEPTH   (MAX_OUTST),
    .entry_t (logic [XLEN-1:0])
  ) u_inflight_pc (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_i),
    .push      (fire),
    .push_data (pc_q),
    .pop       (rsp_accept),
    .head      (inflight_pc),
    .count     (pc_cnt)
  );

  assign fq_push_data = '{pc: inflight_pc, instr: icache_rsp_ins_i};

  if_fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fetch_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_i),
    .push      (rsp_accept),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .head      (fq_head),
    .count     (fq_count)
  );

  assign id_valid_o = (fq_count != '0);
  assign id_pc_o    = fq_head.pc;
  assign id_instr_o = fq_head.instr;

  // An Icache returning more responses than requested is a protocol violation.
  assert property (@(posedge clk) disable iff (rst)
    icache_rsp_vld_i |-> (outst_q != '0));

  assert property (@(posedge clk) disable iff (rst)
    rsp_accept |-> (pc_cnt != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle Icache model and a delivery scoreboard.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        icache_req_o;
  logic [31:0] icache_req_pc_o;
  logic        icache_req_rdy_i = 1'b1;
  logic        icache_rsp_vld_i = 1'b0;
  logic [31:0] icache_rsp_ins_i = '0;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i = 1'b1;

  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] last_fire_pc = '0;
  bit          rsp_hold = 1'b0;
  bit          wrap_seen = 1'b0;

  if_fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (RESET_PC),
    .FQ_DEPTH  (4),
    .MAX_OUTST (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .icache_req_o     (icache_req_o),
    .icache_req_pc_o  (icache_req_pc_o),
    .icache_req_rdy_i (icache_req_rdy_i),
    .icache_rsp_vld_i (icache_rsp_vld_i),
    .icache_rsp_ins_i (icache_rsp_ins_i),
    .id_valid_o       (id_valid_o),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o),
    .id_ready_i       (id_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hC3A5, pc[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Icache model plus scoreboard, evaluated mid-cycle when all inputs are settled.
  task automatic model_step();
    logic [31:0] e;
    if (rst) begin
      icache_rsp_vld_i = 1'b0;
      return;
    end
    if (id_valid_o && id_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_id_valid", {31'b0, id_valid_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_pc_o, e);
        check("id_instr", id_instr_o, instr_of(e));
        delivered++;
        $display("deliver pc=%h instr=%h", id_pc_o, id_instr_o);
      end
    end
    if (redirect_valid_i) begin
      check("req_during_redirect", {31'b0, icache_req_o}, 32'd0);
      exp_q.delete();
      exp_req_pc = redirect_pc_i;
    end
    if (!rsp_hold && pend_q.size() != 0) begin
      e = pend_q.pop_front();
      icache_rsp_vld_i = 1'b1;
      icache_rsp_ins_i = instr_of(e);
    end else begin
      icache_rsp_vld_i = 1'b0;
      icache_rsp_ins_i = '0;
    end
    if (icache_req_o && icache_req_rdy_i) begin
      check("req_pc", icache_req_pc_o, exp_req_pc);
      if (last_fire_pc == 32'hFFFF_FFFC && icache_req_pc_o == 32'h0) wrap_seen = 1'b1;
      last_fire_pc = icache_req_pc_o;
      pend_q.push_back(icache_req_pc_o);
      exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
    end
  endtask

  always @(negedge clk) model_step();

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) mid();
    check("rst_req", {31'b0, icache_req_o}, 32'd0);
    check("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
    drv();
    rst = 1'b0;

    // 1: streaming fetch, first delivery two cycles after the first fire
    mid();
    check("t1_req0", {31'b0, icache_req_o}, 32'd1);
    check("t1_req_pc0", icache_req_pc_o, RESET_PC);
    check("t1_idv_c0", {31'b0, id_valid_o}, 32'd0);
    mid();
    check("t1_idv_c1", {31'b0, id_valid_o}, 32'd0);
    mid();
    check("t1_idv_c2", {31'b0, id_valid_o}, 32'd1);
    check("t1_id_pc_c2", id_pc_o, RESET_PC);
    repeat (8) mid();
    check("t1_throughput", 32'(delivered), 32'd9);

    // 2: downstream stall fills the queue; requests stop on credit
    drv();
    id_ready_i = 1'b0;
    repeat (10) mid();
    check("t2_req_stalled", {31'b0, icache_req_o}, 32'd0);
    check("t2_id_valid", {31'b0, id_valid_o}, 32'd1);
    check("t2_queued", 32'(exp_q.size()), 32'd4);
    check("t2_head_pc", id_pc_o, exp_q[0]);
    drv();
    id_ready_i = 1'b1;
    repeat (6) mid();

    // 3: redirect with two requests outstanding and a non-empty queue
    drv();
    id_ready_i = 1'b0;
    rsp_hold = 1'b1;
    repeat (4) mid();
    check("t3_pre_idv", {31'b0, id_valid_o}, 32'd1);
    check("t3_pre_outst", 32'(pend_q.size()), 32'd2);
    drv();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h100;
    mid();
    drv();
    redirect_valid_i = 1'b0;
    mid();
    check("t3_flushed", {31'b0, id_valid_o}, 32'd0);
    check("t3_no_credit", {31'b0, icache_req_o}, 32'd0);
    drv();
    rsp_hold = 1'b0;
    id_ready_i = 1'b1;
    for (int i = 0; i < 10 && !id_valid_o; i++) mid();
    check("t3_first_valid", {31'b0, id_valid_o}, 32'd1);
    check("t3_first_pc", id_pc_o, 32'h100);
    repeat (3) mid();

    // 4: redirect while a response lands and the head is popped
    drv();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h200;
    mid();
    check("t4_pop_at_redirect", {31'b0, id_valid_o}, 32'd1);
    drv();
    redirect_valid_i = 1'b0;
    mid();
    check("t4_flushed", {31'b0, id_valid_o}, 32'd0);
    check("t4_req", {31'b0, icache_req_o}, 32'd1);
    check("t4_req_pc", icache_req_pc_o, 32'h200);
    for (int i = 0; i < 10 && !id_valid_o; i++) mid();
    check("t4_first_pc", id_pc_o, 32'h200);
    repeat (3) mid();

    // 5: PC wraps past the top of the address space
    drv();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    drv();
    redirect_valid_i = 1'b0;
    repeat (6) mid();
    check("t5_wrap", {31'b0, wrap_seen}, 32'd1);

    // 6: asynchronous reset with the queue full
    drv();
    id_ready_i = 1'b0;
    repeat (8) mid();
    check("t6_full_idv", {31'b0, id_valid_o}, 32'd1);
    check("t6_full_cnt", 32'(exp_q.size()), 32'd4);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_req", {31'b0, icache_req_o}, 32'd0);
    check("t6_async_idv", {31'b0, id_valid_o}, 32'd0);
    pend_q.delete();
    exp_q.delete();
    exp_req_pc = RESET_PC;
    id_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mid();
    check("t6_refetch_req", {31'b0, icache_req_o}, 32'd1);
    check("t6_refetch_pc", icache_req_pc_o, RESET_PC);
    check("t6_refetch_idv", {31'b0, id_valid_o}, 32'd0);
    delivered = 0;
    repeat (6) mid();
    check("t6_delivered", 32'(delivered), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
